// File: rtl/front_panel_loader.sv
// rtl/front_panel_loader.sv - front-panel program loader: debounced buttons drive deposit/examine/run of CPU memory
// Optional deposit checksum is built only when LOADER_CHECKSUM_EN is defined.
module front_panel_loader #(
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int ADDR_W          = 8,
  parameter int DATA_W          = 8
) (
  input  logic              CLK_12MHz,
  input  logic              reset,
  input  logic [4:0]        btn_n,
  input  logic [DATA_W-1:0] dip_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic [DATA_W-1:0] display,
  output logic [DATA_W-1:0] checksum
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_START,
    S_RUN
  } state_t;

  state_t state, state_nxt;

  logic [4:0]        btn_s1, btn_s2, btn_deb, btn_deb_q;
  logic [DATA_W-1:0] dip_s1, dip_s2;
  logic [CNT_W-1:0]  deb_cnt [5];
  logic [4:0]        press, press_sel;
  logic [ADDR_W-1:0] addr;

  // Two-flop synchronizers; buttons idle released (high).
  always_ff @(posedge CLK_12MHz) begin
    if (reset) begin
      btn_s1 <= '1;
      btn_s2 <= '1;
      dip_s1 <= '0;
      dip_s2 <= '0;
    end else begin
      btn_s1 <= btn_n;
      btn_s2 <= btn_s1;
      dip_s1 <= dip_in;
      dip_s2 <= dip_s1;
    end
  end

  always_ff @(posedge CLK_12MHz) begin
    if (reset) begin
      btn_deb   <= '1;
      btn_deb_q <= '1;
      for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
    end else begin
      btn_deb_q <= btn_deb;
      for (int i = 0; i < 5; i++) begin
        if (btn_s2[i] != btn_deb[i]) begin
          if (deb_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_deb[i] <= btn_s2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Lowest set bit wins: SETADDR has top priority, STOP the lowest.
  assign press     = btn_deb_q & ~btn_deb;
  assign press_sel = press & (~press + 5'd1);

  always_ff @(posedge CLK_12MHz) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: begin
        if (press_sel[1])      state_nxt = S_WRITE;
        else if (press_sel[2]) state_nxt = S_READ;
        else if (press_sel[3]) state_nxt = S_START;
      end
      S_WRITE:   state_nxt = S_LOAD;
      S_READ:    state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_LOAD;
      S_START:   state_nxt = S_RUN;
      S_RUN:     if (press_sel[4]) state_nxt = S_LOAD;
      default:   state_nxt = S_LOAD;
    endcase
  end

  // Strobes and hold are registered from the next state so they align with it.
  always_ff @(posedge CLK_12MHz) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      cpu_start <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      mem_we    <= (state_nxt == S_WRITE);
      mem_re    <= (state_nxt == S_READ);
      cpu_start <= (state_nxt == S_START);
      cpu_hold  <= !((state_nxt == S_START) || (state_nxt == S_RUN));
    end
  end

  always_ff @(posedge CLK_12MHz) begin
    if (reset) begin
      addr    <= '0;
      display <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (press_sel[0]) begin
            addr    <= ADDR_W'(dip_s2);
            display <= dip_s2;
          end
        end
        S_WRITE: begin
          addr    <= addr + ADDR_W'(1);
          display <= dip_s2;
        end
        S_CAPTURE: begin
          addr    <= addr + ADDR_W'(1);
          display <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr;
  assign mem_wdata = dip_s2;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] cksum;

  always_ff @(posedge CLK_12MHz) begin
    if (reset)                            cksum <= '0;
    else if (state == S_LOAD && press_sel[0]) cksum <= '0;
    else if (state == S_WRITE)            cksum <= cksum + dip_s2;
  end

  assign checksum = cksum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_front_panel_loader.sv
// tb/tb_front_panel_loader.sv - randomized operator-level bench for front_panel_loader
// Expected checksum follows LOADER_CHECKSUM_EN.
module tb_front_panel_loader;

  localparam int DEB = 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic       CLK_12MHz = 1'b0;
  logic       reset;
  logic [4:0] btn_n;
  logic [7:0] dip_in;
  logic [7:0] mem_addr, mem_wdata, mem_rdata, display, checksum;
  logic       mem_we, mem_re, cpu_hold, cpu_start;

  front_panel_loader #(.DEBOUNCE_CYCLES(DEB), .ADDR_W(8), .DATA_W(8)) dut (
    .CLK_12MHz(CLK_12MHz), .reset(reset), .btn_n(btn_n), .dip_in(dip_in),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .cpu_start(cpu_start),
    .display(display), .checksum(checksum)
  );

  always #5 CLK_12MHz = ~CLK_12MHz;

  // CPU memory: synchronous read, preset to a seeded pattern while reset is high.
  logic [7:0] ram [256];
  logic [7:0] seed;
  always @(posedge CLK_12MHz) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37) ^ seed;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end

  int n_tests = 0, n_fail = 0, cyc = 0;
  int we_cnt, re_cnt, st_cnt, overlap, st_hold_bad, first_we;
  logic [7:0] we_addr, we_data, re_addr;

  logic [7:0] m_mem [256];
  logic [7:0] m_addr, m_disp, m_sum;
  bit         m_run;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK_12MHz);
    cyc++;
    if (mem_we) begin
      we_cnt++;
      we_addr = mem_addr;
      we_data = mem_wdata;
      if (first_we < 0) first_we = cyc;
    end
    if (mem_re) begin
      re_cnt++;
      re_addr = mem_addr;
    end
    if (cpu_start) begin
      st_cnt++;
      if (cpu_hold) st_hold_bad++;
    end
    if (mem_we && mem_re) overlap++;
  endtask

  task automatic clear_obs();
    we_cnt = 0; re_cnt = 0; st_cnt = 0; overlap = 0; st_hold_bad = 0; first_we = -1;
  endtask

  task automatic press(input logic [4:0] mask, input logic [7:0] dip);
    dip_in = dip;
    clear_obs();
    btn_n = ~mask;
    repeat (DEB + 6) step();
    btn_n = '1;
    repeat (DEB + 6) step();
  endtask

  task automatic check_state();
    check("mem_addr", mem_addr, m_addr);
    check("display", display, m_disp);
    check("checksum", checksum, CK_EN ? m_sum : 8'h00);
    check("cpu_hold", cpu_hold, !m_run);
    check("strobe_overlap", overlap, 0);
  endtask

  // Operator-level model: one accepted press, chosen by priority, acts on the loader.
  task automatic expect_mask(input logic [4:0] mask, input logic [7:0] dip);
    int op, exp_we, exp_re, exp_st;
    op = -1; exp_we = 0; exp_re = 0; exp_st = 0;
    for (int b = 4; b >= 0; b--) if (mask[b]) op = b;
    if (!m_run) begin
      case (op)
        0: begin
          m_addr = dip; m_disp = dip; m_sum = 8'h00;
        end
        1: begin
          exp_we = 1;
          check("we_addr", we_addr, m_addr);
          check("we_data", we_data, dip);
          m_mem[m_addr] = dip; m_disp = dip; m_sum = m_sum + dip; m_addr = m_addr + 8'd1;
        end
        2: begin
          exp_re = 1;
          check("re_addr", re_addr, m_addr);
          m_disp = m_mem[m_addr]; m_addr = m_addr + 8'd1;
        end
        3: begin
          exp_st = 1; m_run = 1'b1;
        end
        default: ;
      endcase
    end else if (op == 4) begin
      m_run = 1'b0;
    end
    check("we_count", we_cnt, exp_we);
    check("re_count", re_cnt, exp_re);
    check("start_count", st_cnt, exp_st);
    if (exp_st != 0) check("hold_at_start", st_hold_bad, 0);
    check_state();
  endtask

  initial begin
    logic [4:0] mask;
    logic [7:0] dip;
    int t0, r;
    reset = 1'b1; btn_n = '1; dip_in = 8'h00;
    seed = 8'($urandom);
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i * 37) ^ seed;
    m_addr = 8'h00; m_disp = 8'h00; m_sum = 8'h00; m_run = 1'b0;
    clear_obs();
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_start", cpu_start, 0);
    check_state();

    // 3-cycle glitch is shorter than the debounce window.
    dip_in = 8'h55; clear_obs();
    btn_n[1] = 1'b0; repeat (3) step();
    btn_n = '1; repeat (14) step();
    expect_mask(5'b00000, 8'h55);

    // First sample at posedge 1; deposit strobe rises six cycles later.
    dip_in = 8'h5A; clear_obs(); t0 = cyc;
    btn_n[1] = 1'b0; repeat (6) step();
    btn_n = '1; repeat (14) step();
    check("press_latency", first_we - t0, DEB + 3);
    expect_mask(5'b00010, 8'h5A);

    dip_in = 8'h3C; clear_obs();
    btn_n[1] = 1'b0; repeat (2) step();
    btn_n[1] = 1'b1; repeat (2) step();
    btn_n[1] = 1'b0; repeat (10) step();
    btn_n = '1; repeat (12) step();
    expect_mask(5'b00010, 8'h3C);

    press(5'b00001, 8'h10); expect_mask(5'b00001, 8'h10);
    check("disp_10", display, 8'h10);
    press(5'b00010, 8'hBF); expect_mask(5'b00010, 8'hBF);
    press(5'b00010, 8'hF0); expect_mask(5'b00010, 8'hF0);
    check("ram_10", ram[8'h10], 8'hBF);
    check("ram_11", ram[8'h11], 8'hF0);
    check("addr_12", mem_addr, 8'h12);
    check("cksum_af", checksum, CK_EN ? 8'hAF : 8'h00);

    press(5'b00001, 8'hFF); expect_mask(5'b00001, 8'hFF);
    press(5'b00010, 8'h06); expect_mask(5'b00010, 8'h06);
    check("ram_ff", ram[8'hFF], 8'h06);
    check("addr_wrap", mem_addr, 8'h00);
    press(5'b00100, 8'h99); expect_mask(5'b00100, 8'h99);
    check("examine_0", display, 8'h5A);
    check("addr_01", mem_addr, 8'h01);

    press(5'b01000, 8'h00); expect_mask(5'b01000, 8'h00);
    press(5'b00010, 8'h44); expect_mask(5'b00010, 8'h44);
    press(5'b10000, 8'h00); expect_mask(5'b10000, 8'h00);

    press(5'b00011, 8'h22); expect_mask(5'b00011, 8'h22);
    check("simul_addr", mem_addr, 8'h22);

    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      dip = 8'($urandom);
      if (r < 2)       mask = 5'b00001;
      else if (r < 5)  mask = 5'b00010;
      else if (r < 7)  mask = 5'b00100;
      else if (r == 7) mask = 5'b01000;
      else if (r == 8) mask = 5'b10000;
      else             mask = 5'($urandom_range(1, 31));
      press(mask, dip);
      expect_mask(mask, dip);
    end
    if (m_run) begin
      press(5'b10000, 8'h00); expect_mask(5'b10000, 8'h00);
    end

    // Reset lands in the WRITE cycle.
    dip_in = 8'h77; clear_obs();
    btn_n[1] = 1'b0;
    for (int k = 0; k < 30 && we_cnt == 0; k++) step();
    check("rst_mid_we_seen", we_cnt, 1);
    reset = 1'b1; btn_n = '1;
    step();
    reset = 1'b0;
    check("rstw_we", mem_we, 0);
    check("rstw_addr", mem_addr, 8'h00);
    check("rstw_hold", cpu_hold, 1);
    check("rstw_cksum", checksum, 8'h00);
    check("rstw_disp", display, 8'h00);
    clear_obs();
    repeat (12) step();
    check("rstw_quiet", we_cnt + re_cnt + st_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/front_panel_loader.md
Name: front_panel_loader

Overview:
- Front-panel program loader: the writer side of the CPU's 256x8 instruction/data memory, which the CPU reads.
- Operator uses the push-buttons and DIP switches to:
  - set an address,
  - deposit bytes,
  - examine bytes,
  - start or stop the CPU.
- Holds the CPU while loading and owns the memory write port in that mode.
- Sits between the board I/O (Switch/DPSwitch/LED) and the CPU's memory and start control.

Parameters:
- DEBOUNCE_CYCLES, 12000: consecutive stable cycles needed to accept a button level change (1 ms at 12 MHz).
- ADDR_W, 8: memory address width.
- DATA_W, 8: memory data width.

Ports:
- CLK_12MHz, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- btn_n, input, 5: raw active-low push-buttons.
  - [0] SETADDR
  - [1] DEPOSIT
  - [2] EXAMINE
  - [3] RUN
  - [4] STOP
- dip_in, input, DATA_W: raw DIP switch value (address or data).
- mem_addr, output, ADDR_W: memory address.
- mem_wdata, output, DATA_W: memory write data.
- mem_we, output, 1: one-cycle write strobe.
- mem_re, output, 1: one-cycle read strobe. Memory has synchronous read, so data is valid the following cycle.
- mem_rdata, input, DATA_W: memory read data.
- cpu_hold, output, 1: 1 holds the CPU (no fetch) and grants the memory port to the loader.
- cpu_start, output, 1: one-cycle pulse. The CPU resets its PC to 0 and begins fetching.
- display, output, DATA_W: value driven to the LEDs.
- checksum, output, DATA_W: running deposit checksum (see Optional Feature).

Behaviour:
- Reset, synchronous and active-high, overrides everything, including mid-WRITE or mid-READ:
  - state=LOAD, addr=0, display=0, checksum=0.
  - mem_we=0, mem_re=0, cpu_start=0, cpu_hold=1.
  - Debounced levels=1 (released), debounce counters=0.
- Input conditioning:
  - Each btn_n bit and all of dip_in pass through a 2-flop synchronizer.
  - Per button: if the synchronized level differs from the debounced level for DEBOUNCE_CYCLES consecutive cycles, the debounced level takes the new value; any mismatch-free cycle clears that button's counter.
  - Press event = debounced 1->0 transition, one-cycle pulse.
  - Release generates no event.
  - Press latency from raw edge to event: 2 + DEBOUNCE_CYCLES cycles.
- Press arbitration: if several events fire in the same cycle, accept exactly one by priority SETADDR > DEPOSIT > EXAMINE > RUN > STOP. The rest are dropped, not queued.
- LOAD state (cpu_hold=1):
  - SETADDR: addr <= dip; display <= dip; stay in LOAD.
  - DEPOSIT: go to WRITE.
  - EXAMINE: go to READ.
  - RUN: go to START.
  - STOP: ignored.
- WRITE (1 cycle):
  - mem_we=1, mem_addr=addr, mem_wdata=dip; display <= dip.
  - Next cycle: addr <= addr+1, modulo 2^ADDR_W (255->0 wrap); go to LOAD.
- READ (1 cycle): mem_re=1, mem_addr=addr; go to CAPTURE.
- CAPTURE (1 cycle): display <= mem_rdata; addr <= addr+1 (with wrap); go to LOAD.
- START (1 cycle): cpu_start=1; cpu_hold goes 0 this cycle; go to RUN.
- RUN state (cpu_hold=0):
  - mem_we and mem_re stay 0.
  - display is frozen.
  - STOP goes to LOAD (cpu_hold=1 on the next cycle).
  - All other buttons are ignored.
- Output timing:
  - mem_addr always reflects addr.
  - mem_wdata reflects dip outside WRITE.
  - Strobes are registered and never asserted together.
- Busy states: presses arriving during WRITE, READ, CAPTURE or START are dropped.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - Each WRITE adds mem_wdata to checksum, modulo 2^DATA_W.
  - SETADDR clears checksum to 0.
  - checksum holds its value in RUN.
- Not defined: checksum tied to 0 and no adder is built. All other behaviour is identical.

Test Plan:
- Debounce (DEBOUNCE_CYCLES=4):
  - Pulse btn_n[1] low for 3 cycles, then release -> no mem_we.
  - Hold low for 6 cycles -> exactly one mem_we, 6 cycles after the falling edge.
  - Bouncing low/high/low before a stable hold -> still a single strobe.
- Load sequence:
  - SETADDR with dip=0x10 -> display=0x10.
  - DEPOSIT with dip 0xBF, then 0xF0 -> writes mem[0x10]=0xBF and mem[0x11]=0xF0; final addr=0x12; display=0xF0.
  - Checksum (with LOADER_CHECKSUM_EN) = 0xAF.
- Wrap and examine:
  - SETADDR 0xFF, DEPOSIT 0x06 -> mem[0xFF]=0x06; addr=0x00.
  - EXAMINE -> mem_re at addr 0; display = mem_rdata on the following cycle; addr=0x01.
- Run and stop:
  - RUN -> cpu_start high for exactly 1 cycle; cpu_hold falls the same cycle.
  - DEPOSIT in RUN -> no mem_we.
  - STOP -> cpu_hold=1 the next cycle.
- Simultaneous presses: SETADDR and DEPOSIT events in the same cycle with dip=0x22 -> addr=0x22 and no mem_we.
- Reset mid-WRITE: assert reset in the WRITE cycle -> next cycle mem_we=0, addr=0, state=LOAD, cpu_hold=1, checksum=0.
